// File: rtl/driver_digital_tube_mux.sv
// Multiplexed N-digit 7-segment scan driver. New values are staged and swapped into the
// display registers only at frame end, so a scan never mixes old and new digits.
module driver_digital_tube_mux #(
  parameter int P_DIGITS   = 4,
  parameter int P_SCAN_CNT = 300_000,
  parameter int P_GUARD    = 16,
  parameter int P_DUTY_W   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic [4*P_DIGITS-1:0] i_hex,
  input  logic [P_DIGITS-1:0]   i_dp,
  input  logic [P_DIGITS-1:0]   i_blank,
  input  logic                  i_lz_en,
  input  logic [P_DUTY_W-1:0]   i_bright,
  output logic [6:0]            o_seg,
  output logic                  o_dp,
  output logic [P_DIGITS-1:0]   o_sel,
  output logic                  o_ack,
  output logic                  o_frame
);

  localparam int CNT_W = (P_SCAN_CNT > 1) ? $clog2(P_SCAN_CNT) : 1;
  localparam int IDX_W = (P_DIGITS > 1) ? $clog2(P_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_SCAN_CNT - 1);
  localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(P_GUARD);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(P_DIGITS - 1);

  // Scan timing
  logic [CNT_W-1:0] cnt_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [P_DUTY_W-1:0] pwm_reg;

  // Staging (written by i_load) and display (what is being scanned) copies
  logic [4*P_DIGITS-1:0] stg_hex_reg, dsp_hex_reg;
  logic [P_DIGITS-1:0]   stg_dp_reg, dsp_dp_reg;
  logic [P_DIGITS-1:0]   stg_blank_reg, dsp_blank_reg;
  logic                  stg_lz_reg, dsp_lz_reg;
  logic [P_DUTY_W-1:0]   stg_bright_reg, dsp_bright_reg;
  logic                  pending_reg;

  // Registered outputs
  logic [6:0]          seg_reg;
  logic                dp_reg;
  logic [P_DIGITS-1:0] sel_reg;
  logic                ack_reg;
  logic                frame_reg;

  assign o_seg   = seg_reg;
  assign o_dp    = dp_reg;
  assign o_sel   = sel_reg;
  assign o_ack   = ack_reg;
  assign o_frame = frame_reg;

  // zero_from[k]: digits k..P_DIGITS-1 all show a bare zero (no dp)
  logic                zero_from [1:P_DIGITS];
  logic [P_DIGITS-1:0] dark_vec;

  assign zero_from[P_DIGITS] = 1'b1;

  for (genvar gi = 0; gi < P_DIGITS; gi++) begin : g_digit
    if (gi == 0) begin : g_lsd
      assign dark_vec[gi] = dsp_blank_reg[gi];
    end else begin : g_upper
      assign zero_from[gi] = (dsp_hex_reg[4*gi +: 4] == 4'h0) && !dsp_dp_reg[gi]
                             && zero_from[gi+1];
      assign dark_vec[gi] = dsp_blank_reg[gi] || (dsp_lz_reg && zero_from[gi]);
    end
  end

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  logic                frame_end;
  logic [3:0]          cur_nib;
  logic                cur_dark;
  logic [6:0]          seg_next;
  logic                dp_next;
  logic [P_DIGITS-1:0] sel_next;

  assign frame_end = (idx_reg == IDX_LAST) && (cnt_reg == CNT_LAST);

  always_comb begin
    cur_nib  = dsp_hex_reg[{idx_reg, 2'b00} +: 4];
    cur_dark = dark_vec[idx_reg];
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    sel_next = '0;
    if (!cur_dark) begin
      seg_next = hex_to_seg(cur_nib);
      dp_next  = ~dsp_dp_reg[idx_reg];
      // Dead-time at slot start keeps the previous digit's segments from ghosting
      if ((cnt_reg >= GUARD_END) && (pwm_reg <= dsp_bright_reg))
        sel_next[idx_reg] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_reg        <= '0;
      idx_reg        <= '0;
      pwm_reg        <= '0;
      stg_hex_reg    <= '0;
      stg_dp_reg     <= '0;
      stg_blank_reg  <= '1;
      stg_lz_reg     <= 1'b0;
      stg_bright_reg <= '1;
      dsp_hex_reg    <= '0;
      dsp_dp_reg     <= '0;
      dsp_blank_reg  <= '1;
      dsp_lz_reg     <= 1'b0;
      dsp_bright_reg <= '1;
      pending_reg    <= 1'b0;
      seg_reg        <= 7'h7F;
      dp_reg         <= 1'b1;
      sel_reg        <= '0;
      ack_reg        <= 1'b0;
      frame_reg      <= 1'b0;
    end else begin
      pwm_reg <= pwm_reg + 1'b1;
      if (cnt_reg == CNT_LAST) begin
        cnt_reg <= '0;
        idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end

      // A load landing exactly on the frame edge skips staging and shows immediately
      if (frame_end && i_load) begin
        dsp_hex_reg    <= i_hex;
        dsp_dp_reg     <= i_dp;
        dsp_blank_reg  <= i_blank;
        dsp_lz_reg     <= i_lz_en;
        dsp_bright_reg <= i_bright;
        pending_reg    <= 1'b0;
      end else if (frame_end && pending_reg) begin
        dsp_hex_reg    <= stg_hex_reg;
        dsp_dp_reg     <= stg_dp_reg;
        dsp_blank_reg  <= stg_blank_reg;
        dsp_lz_reg     <= stg_lz_reg;
        dsp_bright_reg <= stg_bright_reg;
        pending_reg    <= 1'b0;
      end else if (i_load) begin
        stg_hex_reg    <= i_hex;
        stg_dp_reg     <= i_dp;
        stg_blank_reg  <= i_blank;
        stg_lz_reg     <= i_lz_en;
        stg_bright_reg <= i_bright;
        pending_reg    <= 1'b1;
      end

      seg_reg   <= seg_next;
      dp_reg    <= dp_next;
      sel_reg   <= sel_next;
      ack_reg   <= frame_end && (i_load || pending_reg);
      frame_reg <= frame_end;
    end
  end

endmodule

// File: tb/tb_driver_digital_tube_mux.sv
// Directed bench for driver_digital_tube_mux: a cycle model pushes expected outputs into a
// queue each clock; they are popped and compared one cycle later, plus per-frame summaries.
module tb_driver_digital_tube_mux;

  localparam int ND = 4;
  localparam int SC = 8;
  localparam int GD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] hex = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blank = '0;
  logic        lz = 1'b0;
  logic [1:0]  bright = '0;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic [3:0]  o_sel;
  logic        o_ack;
  logic        o_frame;

  driver_digital_tube_mux #(
    .P_DIGITS(ND), .P_SCAN_CNT(SC), .P_GUARD(GD), .P_DUTY_W(2)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_hex(hex), .i_dp(dp),
    .i_blank(blank), .i_lz_en(lz), .i_bright(bright),
    .o_seg(o_seg), .o_dp(o_dp), .o_sel(o_sel), .o_ack(o_ack), .o_frame(o_frame)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] sel;
    logic       ack;
    logic       frame;
  } exp_t;

  exp_t exp_q[$];
  logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // Reference model state
  int m_cnt = 0, m_idx = 0, m_pwm = 0;
  logic [15:0] m_hex = '0, s_hex = '0;
  logic [3:0]  m_dp = '0, s_dp = '0, m_blank = '1, s_blank = '1;
  logic        m_lz = 1'b0, s_lz = 1'b0, m_pend = 1'b0;
  logic [1:0]  m_bright = 2'd3, s_bright = 2'd3;

  int n_checks = 0;
  int n_errors = 0;

  // Observation statistics
  int ack_cnt, frame_cnt;
  logic [3:0] sel_or;
  int sel_hi [4];
  int guard_hits;
  logic [6:0] seg_mid [4];
  logic dp_mid [4];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    logic fe, supp, dark;
    e.seg = 7'h7F; e.dp = 1'b1; e.sel = '0; e.ack = 1'b0; e.frame = 1'b0;
    if (!rst_n) return e;
    fe = (m_idx == ND - 1) && (m_cnt == SC - 1);
    e.frame = fe;
    e.ack = fe && (m_pend || load);
    supp = 1'b0;
    if (m_lz && m_idx > 0) begin
      supp = 1'b1;
      for (int j = m_idx; j < ND; j++)
        if (m_hex[4*j +: 4] != 4'h0 || m_dp[j]) supp = 1'b0;
    end
    dark = m_blank[m_idx] || supp;
    if (!dark) begin
      e.seg = seg_tab[m_hex[4*m_idx +: 4]];
      e.dp = ~m_dp[m_idx];
      if (m_cnt >= GD && m_pwm <= int'(m_bright)) e.sel = 4'b0001 << m_idx;
    end
    return e;
  endfunction

  task automatic model_step();
    logic fe;
    if (!rst_n) begin
      m_cnt = 0; m_idx = 0; m_pwm = 0; m_pend = 1'b0;
      m_hex = '0; m_dp = '0; m_blank = '1; m_lz = 1'b0; m_bright = 2'd3;
      return;
    end
    fe = (m_idx == ND - 1) && (m_cnt == SC - 1);
    if (fe && load) begin
      m_hex = hex; m_dp = dp; m_blank = blank; m_lz = lz; m_bright = bright; m_pend = 1'b0;
    end else if (fe && m_pend) begin
      m_hex = s_hex; m_dp = s_dp; m_blank = s_blank; m_lz = s_lz; m_bright = s_bright;
      m_pend = 1'b0;
    end else if (load) begin
      s_hex = hex; s_dp = dp; s_blank = blank; s_lz = lz; s_bright = bright; m_pend = 1'b1;
    end
    m_pwm = (m_pwm + 1) % 4;
    if (m_cnt == SC - 1) begin
      m_cnt = 0;
      m_idx = (m_idx + 1) % ND;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic cycle();
    exp_t e;
    exp_q.push_back(model_out());
    model_step();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("seg", 16'(o_seg), 16'(e.seg));
    chk("dp", 16'(o_dp), 16'(e.dp));
    chk("sel", 16'(o_sel), 16'(e.sel));
    chk("ack", 16'(o_ack), 16'(e.ack));
    chk("frame", 16'(o_frame), 16'(e.frame));
    if (o_ack) ack_cnt++;
    if (o_frame) frame_cnt++;
    sel_or |= o_sel;
  endtask

  task automatic clear_stats();
    ack_cnt = 0; frame_cnt = 0; sel_or = '0; guard_hits = 0;
    for (int k = 0; k < 4; k++) begin
      sel_hi[k] = 0; seg_mid[k] = 'x; dp_mid[k] = 1'bx;
    end
  endtask

  task automatic do_load(input logic [15:0] h, input logic [3:0] d, input logic [3:0] b,
                         input logic l, input logic [1:0] br);
    hex = h; dp = d; blank = b; lz = l; bright = br;
    load = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  task automatic run_until_frame();
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!o_frame && n < 100);
    chk("frame_timeout", 16'(o_frame), 16'd1);
  endtask

  // Call right after a frame pulse was observed: the next 32 observations are one frame
  task automatic run_frame();
    clear_stats();
    for (int j = 0; j < ND * SC; j++) begin
      cycle();
      for (int k = 0; k < ND; k++) if (o_sel[k]) sel_hi[k]++;
      if ((j % SC) < GD && o_sel != 0) guard_hits++;
      if ((j % SC) == 4) begin
        seg_mid[j / SC] = o_seg;
        dp_mid[j / SC] = o_dp;
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_seg"}, 16'(o_seg), 16'h7F);
    chk({tag, "_dp"}, 16'(o_dp), 16'd1);
    chk({tag, "_sel"}, 16'(o_sel), 16'd0);
    chk({tag, "_ack"}, 16'(o_ack), 16'd0);
    chk({tag, "_frame"}, 16'(o_frame), 16'd0);
  endtask

  initial begin
    clear_stats();
    // Reset
    rst_n = 1'b0;
    cycle();
    cycle();
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Basic scan of 1234 at full brightness
    clear_stats();
    do_load(16'h1234, 4'b0000, 4'b0000, 1'b0, 2'd3);
    run_until_frame();
    chk("s1_ack_cnt", 16'(ack_cnt), 16'd1);
    run_frame();
    for (int k = 0; k < ND; k++) chk($sformatf("s1_sel_hi%0d", k), 16'(sel_hi[k]), 16'd6);
    chk("s1_guard", 16'(guard_hits), 16'd0);
    chk("s1_seg0", 16'(seg_mid[0]), 16'(7'b1001100));
    chk("s1_seg1", 16'(seg_mid[1]), 16'(7'b0000110));

    // Two loads in one frame: last wins, one ack with the frame pulse
    clear_stats();
    repeat (3) cycle();
    do_load(16'hAAAA, 4'b0000, 4'b0000, 1'b0, 2'd3);
    repeat (5) cycle();
    do_load(16'h5555, 4'b0000, 4'b0000, 1'b0, 2'd3);
    run_until_frame();
    chk("s2_ack_cnt", 16'(ack_cnt), 16'd1);
    chk("s2_ack_with_frame", 16'(o_ack), 16'd1);
    run_frame();
    chk("s2_seg0", 16'(seg_mid[0]), 16'(7'b0100100));
    chk("s2_seg3", 16'(seg_mid[3]), 16'(7'b0100100));
    chk("s2_no_ack", 16'(ack_cnt), 16'd1 - 16'(o_ack) + 16'(o_ack) - 16'd1);

    // Leading-zero suppression
    do_load(16'h0050, 4'b0000, 4'b0000, 1'b1, 2'd3);
    run_until_frame();
    run_frame();
    chk("s3_sel_hi32", 16'(sel_or & 4'b1100), 16'd0);
    chk("s3_seg1", 16'(seg_mid[1]), 16'(7'b0100100));
    chk("s3_seg0", 16'(seg_mid[0]), 16'(7'b0000001));
    chk("s3_seg3_dark", 16'(seg_mid[3]), 16'h7F);
    do_load(16'h0000, 4'b0000, 4'b0000, 1'b1, 2'd3);
    run_until_frame();
    run_frame();
    chk("s3_zero_only_d0", 16'(sel_or), 16'b0001);
    do_load(16'h0050, 4'b0100, 4'b0000, 1'b1, 2'd3);
    run_until_frame();
    run_frame();
    chk("s3_dp_seg2", 16'(seg_mid[2]), 16'(7'b0000001));
    chk("s3_dp_dp2", 16'(dp_mid[2]), 16'd0);
    chk("s3_dp_sel2", 16'(sel_hi[2]), 16'd6);
    chk("s3_dp_sel3", 16'(sel_hi[3]), 16'd0);

    // Brightness: pwm stays aligned to cnt mod 4, so outside guard pwm==0 only at cnt 4
    do_load(16'h1234, 4'b0000, 4'b0000, 1'b0, 2'd0);
    run_until_frame();
    run_frame();
    chk("s4_br0_sel0", 16'(sel_hi[0]), 16'd1);
    chk("s4_br0_sel2", 16'(sel_hi[2]), 16'd1);
    do_load(16'h1234, 4'b0000, 4'b0000, 1'b0, 2'd1);
    run_until_frame();
    run_frame();
    chk("s4_br1_sel1", 16'(sel_hi[1]), 16'd2);
    do_load(16'h1234, 4'b0000, 4'b0010, 1'b0, 2'd3);
    run_until_frame();
    run_frame();
    chk("s4_blank_sel1", 16'(sel_hi[1]), 16'd0);
    chk("s4_blank_seg1", 16'(seg_mid[1]), 16'h7F);
    chk("s4_blank_dp1", 16'(dp_mid[1]), 16'd1);
    chk("s4_blank_sel0", 16'(sel_hi[0]), 16'd6);

    // Load coincident with the frame-end edge takes effect immediately
    while (!(m_idx == ND - 1 && m_cnt == SC - 1)) cycle();
    do_load(16'hF00D, 4'b0000, 4'b0000, 1'b0, 2'd3);
    chk("s5_ack", 16'(o_ack), 16'd1);
    chk("s5_frame", 16'(o_frame), 16'd1);
    run_frame();
    chk("s5_seg0", 16'(seg_mid[0]), 16'(7'b1000010));
    chk("s5_seg3", 16'(seg_mid[3]), 16'(7'b0111000));

    // Reset mid-frame with a pending load
    repeat (5) cycle();
    do_load(16'h8888, 4'b0000, 4'b0000, 1'b0, 2'd3);
    repeat (2) cycle();
    rst_n = 1'b0;
    cycle();
    chk_reset_outputs("midrst");
    rst_n = 1'b1;
    clear_stats();
    repeat (2 * ND * SC) cycle();
    chk("s6_frames", 16'(frame_cnt), 16'd2);
    chk("s6_acks", 16'(ack_cnt), 16'd0);
    chk("s6_sel_or", 16'(sel_or), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
